// File: rtl/hsid_stream_ctrl.sv
// Sequencer that launches hsid_main, then fetches the captured pixel and the library over an OBI-style
// read port. Words are streamed in order through a small response buffer, under hsid_main's ready.
module hsid_stream_ctrl #(
    parameter int WORD_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int HSP_BANDS_WIDTH   = 12,
    parameter int HSP_LIBRARY_WIDTH = 8,
    parameter int BUF_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         clear,
    input  logic [ADDR_WIDTH-1:0]        cap_base_addr,
    input  logic [ADDR_WIDTH-1:0]        lib_base_addr,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [WORD_WIDTH-1:0]        mem_rdata,
    input  logic                         mem_err,
    output logic                         main_start,
    output logic                         main_clear,
    output logic [WORD_WIDTH-1:0]        main_data,
    output logic                         main_data_valid,
    input  logic                         main_ready,
    input  logic                         main_done,
    input  logic                         main_error,
    output logic                         idle,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         cancelled
);

    localparam int CNT_W = HSP_LIBRARY_WIDTH + HSP_BANDS_WIDTH;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [3:0] SC_IDLE      = 4'd0;
    localparam logic [3:0] SC_CONFIG    = 4'd1;
    localparam logic [3:0] SC_CAPTURED  = 4'd2;
    localparam logic [3:0] SC_LIBRARY   = 4'd3;
    localparam logic [3:0] SC_DRAIN     = 4'd4;
    localparam logic [3:0] SC_WAIT_DONE = 4'd5;
    localparam logic [3:0] SC_DONE      = 4'd6;
    localparam logic [3:0] SC_ERROR     = 4'd7;
    localparam logic [3:0] SC_ABORT     = 4'd8;
    localparam logic [3:0] SC_FLUSH     = 4'd9;
    localparam logic [3:0] SC_CANCEL    = 4'd10;

    localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
    localparam logic [OCC_W-1:0]           OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W:0]             DEPTH_CMP = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0]           PTR_ONE   = PTR_W'(1);
    localparam logic [HSP_BANDS_WIDTH:0]   BANDS_ONE = (HSP_BANDS_WIDTH + 1)'(1);
    localparam logic [HSP_BANDS_WIDTH-1:0] MIN_BANDS = HSP_BANDS_WIDTH'(7);
    localparam logic [ADDR_WIDTH-1:0]      ADDR_FOUR = ADDR_WIDTH'(4);

    logic [3:0]                   state_reg, state_next;
    logic [ADDR_WIDTH-1:0]        cap_base_reg, lib_base_reg, addr_reg;
    logic [HSP_BANDS_WIDTH-1:0]   bands_reg;
    logic [HSP_LIBRARY_WIDTH-1:0] lib_size_reg;
    logic [HSP_BANDS_WIDTH:0]     w_reg;
    logic [CNT_W-1:0]             lib_total_reg, req_cnt_reg;
    logic [OCC_W-1:0]             outstanding_reg, fill_reg;
    logic [PTR_W-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [WORD_WIDTH-1:0]        buf_mem [BUF_DEPTH];

    logic            streaming, issuing, cfg_ok, gnt_fire, rsp_dec, rsp_err;
    logic            clear_take, abort_req, flush, wr_en, pop, cap_last, lib_last;
    logic [OCC_W:0]  inflight;

    assign streaming  = (state_reg == SC_CAPTURED) || (state_reg == SC_LIBRARY) || (state_reg == SC_DRAIN);
    assign issuing    = (state_reg == SC_CAPTURED) || (state_reg == SC_LIBRARY);
    assign cfg_ok     = (bands_reg >= MIN_BANDS) && (lib_size_reg != '0);
    assign inflight   = {1'b0, outstanding_reg} + {1'b0, fill_reg};
    // Buffered words count against the budget so every granted read has a guaranteed slot.
    assign mem_req    = issuing && (inflight < DEPTH_CMP);
    assign mem_addr   = addr_reg;
    assign gnt_fire   = mem_req && mem_gnt;
    assign rsp_dec    = mem_rvalid && (outstanding_reg != '0);
    assign rsp_err    = streaming && mem_rvalid && mem_err;
    assign clear_take = clear && (state_reg != SC_IDLE);
    assign abort_req  = streaming && (rsp_err || main_error);
    assign flush      = clear_take || abort_req;
    assign wr_en      = streaming && mem_rvalid && !mem_err;
    assign pop        = main_data_valid;
    assign cap_last   = (req_cnt_reg + CNT_ONE) == CNT_W'(w_reg);
    assign lib_last   = (req_cnt_reg + CNT_ONE) == lib_total_reg;

    assign main_start      = (state_reg == SC_CONFIG) && cfg_ok && !clear;
    assign main_clear      = clear_take || rsp_err;
    assign main_data_valid = streaming && (fill_reg != '0) && main_ready;
    assign main_data       = main_data_valid ? buf_mem[rd_ptr_reg] : '0;

    assign idle      = (state_reg == SC_IDLE);
    assign busy      = !((state_reg == SC_IDLE) || (state_reg == SC_DONE) ||
                         (state_reg == SC_ERROR) || (state_reg == SC_CANCEL));
    assign done      = (state_reg == SC_DONE);
    assign error     = (state_reg == SC_ERROR);
    assign cancelled = (state_reg == SC_CANCEL);

    always_comb begin
        state_next = state_reg;
        if (clear_take) begin
            state_next = SC_FLUSH;
        end else begin
            case (state_reg)
                SC_IDLE:      if (start) state_next = SC_CONFIG;
                SC_CONFIG:    state_next = cfg_ok ? SC_CAPTURED : SC_ERROR;
                SC_CAPTURED: begin
                    if (abort_req)                 state_next = SC_ABORT;
                    else if (gnt_fire && cap_last) state_next = SC_LIBRARY;
                end
                SC_LIBRARY: begin
                    if (abort_req)                 state_next = SC_ABORT;
                    else if (gnt_fire && lib_last) state_next = SC_DRAIN;
                end
                SC_DRAIN: begin
                    if (abort_req) state_next = SC_ABORT;
                    else if (outstanding_reg == '0 && fill_reg == '0) state_next = SC_WAIT_DONE;
                end
                SC_WAIT_DONE: begin
                    if (main_done)       state_next = SC_DONE;
                    else if (main_error) state_next = SC_ERROR;
                end
                SC_ABORT:     if (outstanding_reg == '0) state_next = SC_ERROR;
                SC_FLUSH:     if (outstanding_reg == '0) state_next = SC_CANCEL;
                default:      state_next = SC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SC_IDLE;
            cap_base_reg  <= '0;
            lib_base_reg  <= '0;
            bands_reg     <= '0;
            lib_size_reg  <= '0;
            w_reg         <= '0;
            lib_total_reg <= '0;
            req_cnt_reg   <= '0;
            addr_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SC_IDLE && start && !clear) begin
                cap_base_reg <= cap_base_addr;
                lib_base_reg <= lib_base_addr;
                bands_reg    <= hsp_bands;
                lib_size_reg <= hsp_library_size;
                w_reg        <= ({1'b0, hsp_bands} + BANDS_ONE) >> 1;
            end
            if (state_reg == SC_CONFIG) begin
                lib_total_reg <= CNT_W'(lib_size_reg) * CNT_W'(w_reg);
                req_cnt_reg   <= '0;
                addr_reg      <= cap_base_reg;
            end else if (gnt_fire) begin
                if (state_reg == SC_CAPTURED && cap_last) begin
                    req_cnt_reg <= '0;
                    addr_reg    <= lib_base_reg;
                end else begin
                    req_cnt_reg <= req_cnt_reg + CNT_ONE;
                    addr_reg    <= addr_reg + ADDR_FOUR;
                end
            end
        end
    end

    // Outstanding tracks every granted read until its response, even ones that will be discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
        end else begin
            case ({gnt_fire, rsp_dec})
                2'b10:   outstanding_reg <= outstanding_reg + OCC_ONE;
                2'b01:   outstanding_reg <= outstanding_reg - OCC_ONE;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   fill_reg <= fill_reg + OCC_ONE;
                2'b01:   fill_reg <= fill_reg - OCC_ONE;
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) buf_mem[wr_ptr_reg] <= mem_rdata;
    end

endmodule
